// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage in front of a combinational instruction ROM. It owns
// the program counter, presents the current PC as the ROM byte address, and
// registers the returned word together with its PC and PC+4. Decode takes the
// result over a valid/ready handshake. Execute can redirect the PC at any time.
// Fetch stops once the PC runs past the populated ROM image.
//
// Build option:
//   MISALIGN_TRAP_EN  When defined, a redirect to a target that is not word
//                     aligned is loaded as-is, raises a sticky misalign_o, and
//                     parks the unit in HALT. When undefined, the target is
//                     forced to word alignment and misalign_o is tied to 0.
//
// Parameters:
//   RESET_PC    PC loaded on reset
//   IMEM_WORDS  populated ROM words; fetch stops at PC >= IMEM_WORDS*4
//   CNT_W       width of the completed-handshake counter
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   imem_addr_o    ROM byte address (the current PC)
//   imem_rdata_i   ROM read data, valid in the same cycle as imem_addr_o
//   redirect_i     taken branch/jump this cycle
//   redirect_pc_i  redirect target
//   if_valid_o     if_* outputs hold a live instruction
//   if_ready_i     decode accepts this cycle
//   if_instr_o     fetched instruction
//   if_pc_o        address of if_instr_o
//   if_pc4_o       if_pc_o + 4
//   halted_o       unit is in HALT
//   fetch_cnt_o    completed handshakes (valid & ready), wraps
//   misalign_o     sticky misaligned-redirect flag (0 unless MISALIGN_TRAP_EN)
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 21,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic             if_valid_o,
  input  logic             if_ready_i,
  output logic [31:0]      if_instr_o,
  output logic [31:0]      if_pc_o,
  output logic [31:0]      if_pc4_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic             misalign_o
);

  // First byte address past the ROM image.
  localparam logic [31:0] PC_END = 32'(IMEM_WORDS) << 2;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic        fire;
  logic        slot_free;
  logic        pc_in_range;
  logic        capture;
  logic [31:0] tgt_pc;
  logic        tgt_misaligned;

  assign fire        = if_valid_o & if_ready_i;
  assign slot_free   = ~if_valid_o | if_ready_i;
  assign pc_in_range = (pc_q < PC_END);
  assign imem_addr_o = pc_q;
  assign halted_o    = (state_q == ST_HALT);

  // Redirect target handling depends on whether misaligned targets trap.
`ifdef MISALIGN_TRAP_EN
  assign tgt_pc         = redirect_pc_i;
  assign tgt_misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
  logic unused_tgt_low;
  assign unused_tgt_low = ^redirect_pc_i[1:0];
  assign tgt_pc         = {redirect_pc_i[31:2], 2'b00};
  assign tgt_misaligned = 1'b0;
`endif

  // Next-state and capture decision. Redirect dominates every state and
  // suppresses capture in its own cycle (the ROM word at the old PC is stale).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    capture = 1'b0;
    if (redirect_i) begin
      state_d = (tgt_misaligned || (tgt_pc >= PC_END)) ? ST_HALT : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN, ST_HOLD: begin
          if (!pc_in_range) begin
            state_d = ST_HALT;
          end else if (slot_free) begin
            capture = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      if_valid_o  <= 1'b0;
      if_instr_o  <= 32'h0;
      if_pc_o     <= 32'h0;
      if_pc4_o    <= 32'h0;
      fetch_cnt_o <= '0;
    end else begin
      // A handshake in the redirect cycle still completes and is counted.
      if (fire) begin
        fetch_cnt_o <= fetch_cnt_o + 1'b1;
      end
      if (redirect_i) begin
        pc_q       <= tgt_pc;
        if_valid_o <= 1'b0;
      end else if (capture) begin
        if_instr_o <= imem_rdata_i;
        if_pc_o    <= pc_q;
        if_pc4_o   <= pc_q + 32'd4;
        if_valid_o <= 1'b1;
        pc_q       <= pc_q + 32'd4;
      end else if (fire) begin
        // Consumed with nothing new to offer (HALT or end of image).
        if_valid_o <= 1'b0;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Sticky until the next redirect, which rewrites it with that target's
  // alignment status.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_o <= 1'b0;
    end else if (redirect_i) begin
      misalign_o <= tgt_misaligned;
    end
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed scenarios for reset, streaming, hold, redirect, halt boundary and
// misaligned redirect, followed by a randomized run checked against a
// transaction-level model: the delivered instruction stream must be the ROM
// read sequentially from the last redirect target, ending at the image end.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int          IMEM_WORDS = 21;
  localparam logic [31:0] PC_END     = 32'd84;

  localparam logic [31:0] ROM [IMEM_WORDS] = '{
    32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233,
    32'h0041F2B3, 32'h004282B3, 32'h02728863, 32'h0041A233,
    32'h00020463, 32'h00000293, 32'h0023A233, 32'h005203B3,
    32'h402383B3, 32'h0471AA23, 32'h06002103, 32'h005104B3,
    32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
    32'h00210063
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        halted;
  logic [15:0] fetch_cnt;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    if (a < PC_END) return ROM[a >> 2];
    return 32'hDEADBEEF;
  endfunction

  always_comb imem_rdata = rom_at(imem_addr);

  if_fetch_unit #(
    .RESET_PC  (32'h0),
    .IMEM_WORDS(IMEM_WORDS),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .if_valid_o   (if_valid),
    .if_ready_i   (if_ready),
    .if_instr_o   (if_instr),
    .if_pc_o      (if_pc),
    .if_pc4_o     (if_pc4),
    .halted_o     (halted),
    .fetch_cnt_o  (fetch_cnt),
    .misalign_o   (misalign)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
    tick(); tick();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
    total++; if (if_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", if_pc4); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    total++; if (fetch_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
  endtask

  // Words 0,4,8,C on consecutive cycles; counter trails the display by one.
  task automatic test_stream;
    rst = 1'b0; if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, if_valid); end
      total++; if (if_instr !== ROM[i]) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, if_instr, ROM[i]); end
      total++; if (if_pc !== 32'(i * 4)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, if_pc, i * 4); end
      total++; if (if_pc4 !== 32'(i * 4 + 4)) begin bad++; $display("FAIL stream_pc4[%0d] got=%h exp=%h", i, if_pc4, i * 4 + 4); end
      total++; if (fetch_cnt !== 16'(i)) begin bad++; $display("FAIL stream_cnt[%0d] got=%0d exp=%0d", i, fetch_cnt, i); end
    end
    total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL stream_addr got=%h exp=10", imem_addr); end
  endtask

  task automatic test_hold;
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, if_valid); end
      total++; if (if_instr !== 32'h0023E233) begin bad++; $display("FAIL hold_instr[%0d] got=%h exp=0023e233", i, if_instr); end
      total++; if (if_pc !== 32'h0C || if_pc4 !== 32'h10) begin bad++; $display("FAIL hold_pc[%0d] got=%h/%h exp=0c/10", i, if_pc, if_pc4); end
      total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL hold_addr[%0d] got=%h exp=10", i, imem_addr); end
      total++; if (fetch_cnt !== 16'd3) begin bad++; $display("FAIL hold_cnt[%0d] got=%0d exp=3", i, fetch_cnt); end
    end
  endtask

  task automatic test_redirect;
    if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", if_valid); end
    total++; if (fetch_cnt !== 16'd4) begin bad++; $display("FAIL redir_cnt got=%0d exp=4", fetch_cnt); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h exp=40", imem_addr); end
    tick();
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL redir_valid got=%b exp=1", if_valid); end
    total++; if (if_instr !== 32'h008001EF) begin bad++; $display("FAIL redir_instr got=%h exp=008001ef", if_instr); end
    total++; if (if_pc !== 32'h40 || if_pc4 !== 32'h44) begin bad++; $display("FAIL redir_pc got=%h/%h exp=40/44", if_pc, if_pc4); end
  endtask

  task automatic test_halt;
    int n = 0;
    logic [31:0] last_pc = 32'hFFFF_FFFF;
    rst = 1'b1; redirect = 1'b0; if_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 60 && !halted; c++) begin
      tick();
      if (if_valid) begin
        total++; if (if_pc !== 32'(n * 4) || if_instr !== rom_at(32'(n * 4))) begin
          bad++; $display("FAIL halt_seq[%0d] got=%h@%h exp=%h@%h", n, if_instr, if_pc, rom_at(32'(n * 4)), n * 4);
        end
        last_pc = if_pc;
        n++;
      end
    end
    total++; if (n != IMEM_WORDS) begin bad++; $display("FAIL halt_count got=%0d exp=%0d", n, IMEM_WORDS); end
    total++; if (last_pc !== 32'h50) begin bad++; $display("FAIL halt_last_pc got=%h exp=50", last_pc); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b exp=0", if_valid); end
    total++; if (fetch_cnt !== 16'd21) begin bad++; $display("FAIL halt_cnt got=%0d exp=21", fetch_cnt); end
    tick(); tick();
    total++; if (if_valid !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL halt_stays got=%b/%b exp=0/1", if_valid, halted); end
  endtask

  task automatic test_halt_redirect;
    redirect = 1'b1; redirect_pc = 32'h48;
    tick();
    redirect = 1'b0;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL hredir_halted got=%b exp=0", halted); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL hredir_flush got=%b exp=0", if_valid); end
    tick();
    total++; if (if_valid !== 1'b1 || if_instr !== 32'h00910133 || if_pc !== 32'h48) begin
      bad++; $display("FAIL hredir_word got=%b %h@%h exp=1 00910133@48", if_valid, if_instr, if_pc);
    end
  endtask

  task automatic test_misalign;
    if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
`ifdef MISALIGN_TRAP_EN
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", misalign); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL mis_halted got=%b exp=1", halted); end
    total++; if (imem_addr !== 32'h42) begin bad++; $display("FAIL mis_addr got=%h exp=42", imem_addr); end
    tick(); tick();
    total++; if (if_valid !== 1'b0 || misalign !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b/%b exp=0/1", if_valid, misalign); end
    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    total++; if (misalign !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b/%b exp=0/0", misalign, halted); end
    tick();
    total++; if (if_valid !== 1'b1 || if_instr !== ROM[0] || if_pc !== 32'h0) begin
      bad++; $display("FAIL mis_resume got=%b %h@%h exp=1 %h@0", if_valid, if_instr, if_pc, ROM[0]);
    end
`else
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_flag got=%b exp=0", misalign); end
    total++; if (imem_addr !== 32'h40 || if_valid !== 1'b0) begin bad++; $display("FAIL mis_align got=%h/%b exp=40/0", imem_addr, if_valid); end
    tick();
    total++; if (if_valid !== 1'b1 || if_instr !== 32'h008001EF || if_pc !== 32'h40) begin
      bad++; $display("FAIL mis_word got=%b %h@%h exp=1 008001ef@40", if_valid, if_instr, if_pc);
    end
`endif
  endtask

  // Model: the accepted stream is ROM read sequentially from the most recent
  // redirect target (or reset PC), never past the end of the image.
  task automatic test_random;
    logic [31:0] mpc = 32'h0;
    int          cnt = 0;
    logic        hold_chk;
    logic [31:0] h_instr, h_pc, h_pc4;
    logic        rdy, rd;
    logic [31:0] tgt;
    rst = 1'b1; redirect = 1'b0; if_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c < 560) begin
        rdy = ($urandom_range(0, 3) != 0);
        rd  = ($urandom_range(0, 7) == 0);
        tgt = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(21, 63)) << 2
                                          : 32'($urandom_range(0, 20)) << 2;
      end else begin
        rdy = 1'b1; rd = 1'b0; tgt = 32'h0;
      end
      if_ready = rdy; redirect = rd; redirect_pc = tgt;
      if (if_valid && rdy) begin
        total++; if (mpc >= PC_END) begin bad++; $display("FAIL rnd_past_end cyc=%0d got_pc=%h exp_none", c, if_pc); end
        total++; if (if_pc !== mpc || if_instr !== rom_at(mpc) || if_pc4 !== mpc + 32'd4) begin
          bad++; $display("FAIL rnd_fire cyc=%0d got=%h@%h/%h exp=%h@%h/%h", c, if_instr, if_pc, if_pc4, rom_at(mpc), mpc, mpc + 32'd4);
        end
        mpc = mpc + 32'd4;
        cnt++;
      end
      hold_chk = if_valid && !rdy && !rd;
      h_instr = if_instr; h_pc = if_pc; h_pc4 = if_pc4;
      if (rd) mpc = tgt;
      tick();
      if (hold_chk) begin
        total++; if (if_valid !== 1'b1 || if_instr !== h_instr || if_pc !== h_pc || if_pc4 !== h_pc4) begin
          bad++; $display("FAIL rnd_hold cyc=%0d got=%b %h@%h exp=1 %h@%h", c, if_valid, if_instr, if_pc, h_instr, h_pc);
        end
      end
      total++; if (fetch_cnt !== 16'(cnt)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, fetch_cnt, cnt); end
    end
    total++; if (halted !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL rnd_drain got=%b/%b exp=1/0", halted, if_valid); end
    total++; if (mpc < PC_END) begin bad++; $display("FAIL rnd_undelivered got_next=%h exp>=%h", mpc, PC_END); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_redirect();
    test_halt();
    test_halt_redirect();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
